// File: rtl/dmux_nway_reg.sv
// Registered N-way demultiplexer: routes or broadcasts one word into per-channel
// one-entry holding registers, each with its own valid/ready handshake.
module dmux_nway_reg #(
    parameter int WIDTH    = 16,
    parameter int SEL_BITS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic [SEL_BITS-1:0]               sel,
    input  logic                              bcast,
    output logic [(1<<SEL_BITS)-1:0]          out_valid,
    input  logic [(1<<SEL_BITS)-1:0]          out_ready,
    output logic [(1<<SEL_BITS)*WIDTH-1:0]    out_data,
    output logic                              busy
);

    localparam int N = 1 << SEL_BITS;

    logic [N-1:0]       valid_q;
    logic [N*WIDTH-1:0] data_q;
    logic [N-1:0]       can_take;
    logic [N-1:0]       load;
    logic               accept;

    // A full channel can still take a word in the cycle its consumer drains it.
    assign can_take = ~valid_q | out_ready;
    assign in_ready = bcast ? (&can_take) : can_take[sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = accept & (bcast | (sel == SEL_BITS'(k)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    valid_q[k]                <= 1'b1;
                    data_q[k*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[k]) begin
                    // Data is kept on drain; only the valid flag drops.
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = |valid_q;

endmodule

// File: doc/dmux_nway_reg.md
# dmux_nway_reg

Parametrised, registered successor to the 8-way demultiplexer. It routes a WIDTH-bit word to one of 2^SEL_BITS output channels, or broadcasts it to all of them. Each channel has a one-entry holding register with valid/ready handshakes on both sides. It sits between a single producer (CPU write path) and several memory-mapped consumers that may stall independently.

## Interface
- WIDTH, default 16: data word width.
- SEL_BITS, default 3: select width; N = 2^SEL_BITS channels.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block can accept the word this cycle.
- in_data  input  WIDTH  word to route.
- sel  input  SEL_BITS  destination channel (ignored when bcast=1).
- bcast  input  1  1 = write word to all N channels.
- out_valid  output  N  bit k: channel k holds an unconsumed word.
- out_ready  input  N  bit k: consumer k takes the word this cycle.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- busy  output  1  OR of out_valid.

## Operation
- Per-channel state: valid[k], data[k]. out_valid = valid and out_data = data, both driven directly from registers with no combinational path from in_data.
- can_take[k] = ~valid[k] | out_ready[k]. A full channel accepts a new word in the same cycle it is drained.
- in_ready:
  - bcast=0: in_ready = can_take[sel].
  - bcast=1: in_ready = AND of can_take over all k.
- Accept = in_valid & in_ready.
- Pop[k] = valid[k] & out_ready[k].
- Per-channel update each clock edge, in priority order:
  - load[k] (accept and (bcast or sel==k)): data[k] <= in_data, valid[k] <= 1. This covers a simultaneous pop on the same channel: the word is replaced and valid stays 1.
  - else pop[k]: valid[k] <= 0. data[k] is held, not cleared.
  - else: hold.
- out_ready on an empty channel has no effect.
- Non-selected channels pop independently in the same cycle as a load.
- in_valid=0: no state change except pops. in_ready is still driven per the rules above.
- Broadcast is all-or-nothing. If any channel is full and not being drained, no channel is written and in_ready=0.
- sel and bcast are sampled only in an accepting cycle.

## Timing
- Reset, asynchronous, takes effect immediately regardless of clk:
  - valid = 0, data = 0, out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 1 during and after reset, since all channels are empty.
- Reset mid-transfer discards every held word. The first accept after reset deassertion is loaded on the next rising edge.
- Latency: a word accepted at edge t appears on out_valid/out_data immediately after edge t (one-cycle register latency).
- Throughput: one word per cycle per channel when the consumer holds out_ready=1.
- busy is registered-equivalent: it is derived only from valid, so it carries no input paths.
- in_ready is combinational from sel, bcast, valid and out_ready. Consumers must not make out_ready depend on in_ready.

## Test plan
- Reset: assert reset between edges with channel 2 holding 0x1234 -> out_valid=00000000, out_data=0 and busy=0 immediately, before the next edge; in_ready=1.
- Routing sweep: WIDTH=16, SEL_BITS=3, out_ready=0, send 0xA000+k to sel=k for k=0..7 -> after 8 edges out_valid=11111111, channel k holds 0xA000+k, in_ready=0 for every sel.
- Backpressure: channel 5 full, out_ready=0, in_valid=1, sel=5, data 0xBEEF -> in_ready=0 and channel 5 keeps its old word. Raise out_ready[5] -> accept occurs that edge, channel 5 = 0xBEEF, out_valid[5] stays 1.
- Broadcast: all channels empty, bcast=1, data 0x5555 -> one edge later all out_valid=1 and every channel = 0x5555. Repeat with channel 3 full and out_ready[3]=0 -> in_ready=0 and no channel changes.
- Concurrent pop: channels 1 and 6 full, out_ready=01000010, load sel=1 data 0x0F0F -> channel 1 valid with 0x0F0F, channel 6 valid=0 with data held.
- Parameter sweep: WIDTH=8, SEL_BITS=1 -> two channels, out_data 16 bits, same routing and reset results as above.
